// File: rtl/cv32e40x_ex_result_fifo_if.sv
// Write-back side of the EX result buffer: head entry plus the WB valid/ready handshake.
// The master modport is the buffer; the slave modport is the write-back stage.
interface cv32e40x_ex_result_fifo_if;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic        wb_rf_we_o;
  logic [4:0]  wb_rf_waddr_o;
  logic [31:0] wb_rf_wdata_o;
  logic [31:0] wb_pc_o;
  logic        wb_illegal_o;

  modport master (
    output wb_valid_o, wb_rf_we_o, wb_rf_waddr_o, wb_rf_wdata_o, wb_pc_o, wb_illegal_o,
    input  wb_ready_i
  );

  modport slave (
    input  wb_valid_o, wb_rf_we_o, wb_rf_waddr_o, wb_rf_wdata_o, wb_pc_o, wb_illegal_o,
    output wb_ready_i
  );
endinterface

// File: rtl/cv32e40x_ex_result_fifo.sv
// EX/WB result buffer: collects the selected functional-unit result and the instruction sideband,
// then hands entries to WB in order. Define CV32E40X_EX_RESULT_FWD_EN to build the forwarding lookup.
module cv32e40x_ex_result_fifo #(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid_i,
  input  logic [NUM_FU-1:0]     fu_sel_i,
  input  logic [NUM_FU-1:0]     fu_valid_i,
  input  logic [NUM_FU*32-1:0]  fu_result_i,
  input  logic                  rf_we_i,
  input  logic [4:0]            rf_waddr_i,
  input  logic [31:0]           pc_i,
  input  logic                  illegal_i,
  input  logic                  kill_i,
  input  logic                  halt_i,
  input  logic                  flush_i,
  output logic [NUM_FU-1:0]     fu_ready_o,
  output logic                  ex_ready_o,
  output logic                  ex_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  input  logic [4:0]            fwd_raddr_i,
  output logic                  fwd_hit_o,
  output logic [31:0]           fwd_wdata_o,
  cv32e40x_ex_result_fifo_if.master wb
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH-1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [DEPTH-1:0] we_q, we_d;
  logic [DEPTH-1:0] illegal_q, illegal_d;
  logic [31:0]      wdata_q [DEPTH];
  logic [31:0]      wdata_d [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [4:0]       waddr_q [DEPTH];
  logic [4:0]       waddr_d [DEPTH];

  logic        space;
  logic        ready;
  logic        push;
  logic        pop;
  logic        wb_valid;
  logic [31:0] sel_wdata;

  // Handshake qualification
  always_comb begin
    ex_valid_o = instr_valid_i && !kill_i && !halt_i && (illegal_i || |(fu_sel_i & fu_valid_i));
    space      = (count_q < DEPTH_CNT) || wb.wb_ready_i;
    ready      = kill_i || (space && !halt_i);
    wb_valid   = (count_q != '0);
    push       = ex_valid_o && space && !flush_i;
    pop        = wb_valid && wb.wb_ready_i && !flush_i;
  end

  assign fu_ready_o = {NUM_FU{ready}};
  assign ex_ready_o = ready;
  assign count_o    = count_q;

  // AND-OR mux keeps the stored result at zero when no unit is selected
  always_comb begin
    sel_wdata = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sel_wdata = sel_wdata | ({32{fu_sel_i[k]}} & fu_result_i[32*k +: 32]);
    end
  end

  always_comb begin
    count_d   = count_q;
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    we_d      = we_q;
    illegal_d = illegal_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    waddr_d   = waddr_q;
    if (flush_i) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (push) begin
        we_d[wptr_q]      = rf_we_i && !illegal_i;
        illegal_d[wptr_q] = illegal_i;
        wdata_d[wptr_q]   = sel_wdata;
        pc_d[wptr_q]      = pc_i;
        waddr_d[wptr_q]   = rf_waddr_i;
        wptr_d            = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      we_q    <= '0;
    end else begin
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      we_q    <= we_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count/pointers and we_q
  always_ff @(posedge clk) begin
    illegal_q <= illegal_d;
    wdata_q   <= wdata_d;
    pc_q      <= pc_d;
    waddr_q   <= waddr_d;
  end

  always_comb begin
    wb.wb_valid_o    = wb_valid;
    wb.wb_rf_we_o    = wb_valid ? we_q[rptr_q]      : 1'b0;
    wb.wb_illegal_o  = wb_valid ? illegal_q[rptr_q] : 1'b0;
    wb.wb_rf_wdata_o = wb_valid ? wdata_q[rptr_q]   : '0;
    wb.wb_pc_o       = wb_valid ? pc_q[rptr_q]      : '0;
    wb.wb_rf_waddr_o = wb_valid ? waddr_q[rptr_q]   : '0;
  end

`ifdef CV32E40X_EX_RESULT_FWD_EN
  logic [PTR_W:0]   fwd_sum;
  logic [PTR_W-1:0] fwd_idx;

  // Walk from oldest to youngest so the last match is the youngest writer
  always_comb begin
    fwd_hit_o   = 1'b0;
    fwd_wdata_o = '0;
    fwd_sum     = '0;
    fwd_idx     = '0;
    for (int a = 0; a < DEPTH; a++) begin
      fwd_sum = {1'b0, rptr_q} + (PTR_W+1)'(a);
      if (fwd_sum >= (PTR_W+1)'(DEPTH)) begin
        fwd_sum = fwd_sum - (PTR_W+1)'(DEPTH);
      end
      fwd_idx = fwd_sum[PTR_W-1:0];
      if ((CNT_W'(a) < count_q) && we_q[fwd_idx] &&
          (waddr_q[fwd_idx] == fwd_raddr_i) && (fwd_raddr_i != 5'd0)) begin
        fwd_hit_o   = 1'b1;
        fwd_wdata_o = wdata_q[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd_raddr;
  assign unused_fwd_raddr = ^fwd_raddr_i;
  assign fwd_hit_o        = 1'b0;
  assign fwd_wdata_o      = '0;
`endif

  a_fu_sel_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(fu_sel_i));

endmodule

// File: tb/tb_cv32e40x_ex_result_fifo.sv
// Directed bench for cv32e40x_ex_result_fifo (NUM_FU=4, DEPTH=2): vector table plus
// hand-written forwarding and asynchronous-reset sequences.
module tb_cv32e40x_ex_result_fifo;
  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid_i;
  logic [3:0]   fu_sel_i, fu_valid_i;
  logic [127:0] fu_result_i;
  logic         rf_we_i;
  logic [4:0]   rf_waddr_i;
  logic [31:0]  pc_i;
  logic         illegal_i, kill_i, halt_i, flush_i;
  logic [3:0]   fu_ready_o;
  logic         ex_ready_o, ex_valid_o;
  logic [1:0]   count_o;
  logic [4:0]   fwd_raddr_i;
  logic         fwd_hit_o;
  logic [31:0]  fwd_wdata_o;

  cv32e40x_ex_result_fifo_if wb_if ();

  cv32e40x_ex_result_fifo #(.NUM_FU(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .instr_valid_i(instr_valid_i), .fu_sel_i(fu_sel_i),
    .fu_valid_i(fu_valid_i), .fu_result_i(fu_result_i), .rf_we_i(rf_we_i),
    .rf_waddr_i(rf_waddr_i), .pc_i(pc_i), .illegal_i(illegal_i), .kill_i(kill_i),
    .halt_i(halt_i), .flush_i(flush_i), .fu_ready_o(fu_ready_o), .ex_ready_o(ex_ready_o),
    .ex_valid_o(ex_valid_o), .count_o(count_o), .fwd_raddr_i(fwd_raddr_i),
    .fwd_hit_o(fwd_hit_o), .fwd_wdata_o(fwd_wdata_o), .wb(wb_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [3:0] sel;
    logic [3:0] vld;
    logic [31:0] data;
    logic       we;
    logic [4:0] waddr;
    logic       ill, kill, halt, flush, wbr;
    logic       e_exv, e_exr;
    logic [1:0] e_cnt;
    logic       e_wbv;
    logic [31:0] e_wdata;
    logic [4:0] e_waddr;
    logic       e_ill, e_we;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[19];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] sel, input logic [3:0] vld,
                       input logic [31:0] data, input logic we, input logic [4:0] waddr,
                       input logic ill, input logic kill, input logic halt,
                       input logic flush, input logic wbr);
    instr_valid_i = iv;
    fu_sel_i      = sel;
    fu_valid_i    = vld;
    for (int k = 0; k < 4; k++) begin
      fu_result_i[32*k +: 32] = sel[k] ? data : (32'hBAD0_0000 | 32'(k));
    end
    rf_we_i      = we;
    rf_waddr_i   = waddr;
    pc_i         = 32'h1000 + {27'd0, waddr};
    illegal_i    = ill;
    kill_i       = kill;
    halt_i       = halt;
    flush_i      = flush;
    wb_if.wb_ready_i = wbr;
  endtask

  function automatic vec_t mk(logic iv, logic [3:0] sel, logic [3:0] vld, logic [31:0] data,
                              logic we, logic [4:0] waddr, logic ill, logic kill, logic halt,
                              logic flush, logic wbr, logic e_exv, logic e_exr, logic [1:0] e_cnt,
                              logic e_wbv, logic [31:0] e_wdata, logic [4:0] e_waddr,
                              logic e_ill, logic e_we);
    vec_t v;
    v.iv = iv; v.sel = sel; v.vld = vld; v.data = data; v.we = we; v.waddr = waddr;
    v.ill = ill; v.kill = kill; v.halt = halt; v.flush = flush; v.wbr = wbr;
    v.e_exv = e_exv; v.e_exr = e_exr; v.e_cnt = e_cnt; v.e_wbv = e_wbv;
    v.e_wdata = e_wdata; v.e_waddr = e_waddr; v.e_ill = e_ill; v.e_we = e_we;
    return v;
  endfunction

  initial begin
    // Expected columns describe the cycle before the edge that consumes the row's inputs
    //           iv sel    vld    data          we wa ill kl ht fl wbr | exv exr cnt wbv wdata         wa ill we
    vecs[0]  = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 4'b0010, 4'b0010, 32'hDEADBEEF, 1, 5, 0, 0, 0, 0, 1,   1, 1, 0, 0, 32'h0,        0, 0, 0);
    vecs[2]  = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1, 32'hDEADBEEF, 5, 0, 1);
    vecs[3]  = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 32'h0,        0, 0, 0);
    vecs[4]  = mk(1, 4'b0001, 4'b0001, 32'hA,        1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 32'h0,        0, 0, 0);
    vecs[5]  = mk(1, 4'b0100, 4'b0100, 32'hB,        1, 2, 0, 0, 0, 0, 0,   1, 1, 1, 1, 32'hA,        1, 0, 1);
    vecs[6]  = mk(1, 4'b1000, 4'b1000, 32'hC,        1, 3, 0, 0, 0, 0, 0,   1, 0, 2, 1, 32'hA,        1, 0, 1);
    vecs[7]  = mk(1, 4'b1000, 4'b1000, 32'hC,        1, 3, 0, 0, 0, 0, 1,   1, 1, 2, 1, 32'hA,        1, 0, 1);
    vecs[8]  = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 0, 1,   0, 1, 2, 1, 32'hB,        2, 0, 1);
    vecs[9]  = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1, 32'hC,        3, 0, 1);
    vecs[10] = mk(1, 4'b0000, 4'b0000, 32'h0,        1, 7, 1, 0, 0, 0, 0,   1, 1, 0, 0, 32'h0,        0, 0, 0);
    vecs[11] = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 32'h0,        7, 1, 0);
    vecs[12] = mk(1, 4'b0010, 4'b0010, 32'h55,       1, 9, 0, 1, 0, 0, 0,   0, 1, 1, 1, 32'h0,        7, 1, 0);
    vecs[13] = mk(1, 4'b0010, 4'b0010, 32'h66,       1, 9, 0, 0, 1, 0, 0,   0, 0, 1, 1, 32'h0,        7, 1, 0);
    vecs[14] = mk(1, 4'b0001, 4'b0001, 32'hD1,       1, 4, 0, 0, 0, 0, 0,   1, 1, 1, 1, 32'h0,        7, 1, 0);
    vecs[15] = mk(1, 4'b0010, 4'b0010, 32'hE,        1, 6, 0, 0, 0, 1, 1,   1, 1, 2, 1, 32'h0,        7, 1, 0);
    vecs[16] = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 32'h0,        0, 0, 0);
    vecs[17] = mk(1, 4'b0010, 4'b0100, 32'h77,       1, 8, 0, 0, 0, 0, 1,   0, 1, 0, 0, 32'h0,        0, 0, 0);
    vecs[18] = mk(0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 32'h0,        0, 0, 0);

    rst = 1'b1;
    fwd_raddr_i = 5'd0;
    drive(0, 4'b0, 4'b0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("reset_count", -1, 32'(count_o), 32'd0);
    chk("reset_wb_valid", -1, 32'(wb_if.wb_valid_o), 32'd0);
    chk("reset_fwd_hit", -1, 32'(fwd_hit_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].we, vecs[i].waddr,
            vecs[i].ill, vecs[i].kill, vecs[i].halt, vecs[i].flush, vecs[i].wbr);
      #1;
      chk("ex_valid", i, 32'(ex_valid_o), 32'(vecs[i].e_exv));
      chk("ex_ready", i, 32'(ex_ready_o), 32'(vecs[i].e_exr));
      chk("fu_ready", i, 32'(fu_ready_o), {28'd0, {4{vecs[i].e_exr}}});
      chk("count", i, 32'(count_o), 32'(vecs[i].e_cnt));
      chk("wb_valid", i, 32'(wb_if.wb_valid_o), 32'(vecs[i].e_wbv));
      chk("wb_wdata", i, wb_if.wb_rf_wdata_o, vecs[i].e_wdata);
      chk("wb_waddr", i, 32'(wb_if.wb_rf_waddr_o), 32'(vecs[i].e_waddr));
      chk("wb_illegal", i, 32'(wb_if.wb_illegal_o), 32'(vecs[i].e_ill));
      chk("wb_rf_we", i, 32'(wb_if.wb_rf_we_o), 32'(vecs[i].e_we));
      chk("wb_pc", i, wb_if.wb_pc_o, vecs[i].e_wbv ? (32'h1000 + 32'(vecs[i].e_waddr)) : 32'h0);
    end

    // Two writers of x3 buffered: the younger one must be forwarded
    @(negedge clk);
    drive(1, 4'b0001, 4'b0001, 32'h11, 1, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 4'b0100, 4'b0100, 32'h22, 1, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 4'b0, 4'b0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    fwd_raddr_i = 5'd3;
    #1;
    chk("fwd_count", 100, 32'(count_o), 32'd2);
    chk("fwd_head_older", 100, wb_if.wb_rf_wdata_o, 32'h11);
`ifdef CV32E40X_EX_RESULT_FWD_EN
    chk("fwd_hit_x3", 100, 32'(fwd_hit_o), 32'd1);
    chk("fwd_wdata_x3", 100, fwd_wdata_o, 32'h22);
`else
    chk("fwd_hit_x3_off", 100, 32'(fwd_hit_o), 32'd0);
    chk("fwd_wdata_x3_off", 100, fwd_wdata_o, 32'h0);
`endif
    fwd_raddr_i = 5'd0;
    #1;
    chk("fwd_hit_x0", 101, 32'(fwd_hit_o), 32'd0);
    fwd_raddr_i = 5'd5;
    #1;
    chk("fwd_hit_x5", 102, 32'(fwd_hit_o), 32'd0);
    fwd_raddr_i = 5'd0;

    // Asynchronous reset pulse strictly between clock edges while full
    @(negedge clk);
    #1;
    chk("pre_rst_count", 200, 32'(count_o), 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_count", 200, 32'(count_o), 32'd0);
    chk("async_rst_wb_valid", 200, 32'(wb_if.wb_valid_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_count", 201, 32'(count_o), 32'd0);
    chk("post_rst_wb_wdata", 201, wb_if.wb_rf_wdata_o, 32'h0);
    @(negedge clk);
    #1;
    chk("after_edge_count", 202, 32'(count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
